// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: two-stage pipelined truncation-based approximate unsigned
// multiplier with valid/ready flow control.
// Optional build macro: APPROX_MUL_MIDPOINT_EN (midpoint substitution of the
// highest truncated bit instead of zero truncation).
module approx_mul_pipe #(
  parameter int unsigned W  = 12,
  parameter int unsigned KW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [KW-1:0]   k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  z
);

  localparam logic [KW-1:0] kMax = KW'(W);

  logic          s1V;
  logic          s2V;
  logic          s1Adv;
  logic          s2Adv;
  logic [KW-1:0] ke;
  logic [W-1:0]  keepMask;
  logic [W-1:0]  ta;
  logic [W-1:0]  tb;
  logic [W-1:0]  s1A;
  logic [W-1:0]  s1B;
`ifdef APPROX_MUL_MIDPOINT_EN
  logic [W-1:0]  midMask;
`endif

  // Handshake: each stage advances when empty or when the stage after it moves.
  always_comb begin
    s2Adv     = !s2V || out_ready;
    s1Adv     = !s1V || s2Adv;
    in_ready  = s1Adv;
    out_valid = s2V;
  end

  // Saturate the truncation depth and build the per-bit keep (and midpoint) masks.
  always_comb begin
    ke       = (k > kMax) ? kMax : k;
    keepMask = '0;
`ifdef APPROX_MUL_MIDPOINT_EN
    midMask  = '0;
`endif
    for (int unsigned i = 0; i < W; i++) begin
      keepMask[i] = (i >= 32'(ke));
`ifdef APPROX_MUL_MIDPOINT_EN
      midMask[i]  = ((i + 1) == 32'(ke));
`endif
    end
`ifdef APPROX_MUL_MIDPOINT_EN
    ta = (a & keepMask) | midMask;
    tb = (b & keepMask) | midMask;
`else
    ta = a & keepMask;
    tb = b & keepMask;
`endif
  end

  // Stage 1: capture truncated operands on input transfer, so k only matters at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1V <= 1'b0;
      s1A <= '0;
      s1B <= '0;
    end else if (s1Adv) begin
      s1V <= in_valid;
      if (in_valid) begin
        s1A <= ta;
        s1B <= tb;
      end
    end
  end

  // Stage 2: register the full-width product; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2V <= 1'b0;
      z   <= '0;
    end else if (s2Adv) begin
      s2V <= s1V;
      if (s1V) begin
        z <= (2*W)'(s1A) * (2*W)'(s1B);
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: table-driven vectors plus hand-written stall, stream and
// reset sequences, checked through an in-order scoreboard.
module tb_approx_mul_pipe;

  localparam int unsigned W  = 12;
  localparam int unsigned KW = 4;

  logic            clk;
  logic            rst;
  logic            inValid;
  logic            inReady;
  logic [W-1:0]    opA;
  logic [W-1:0]    opB;
  logic [KW-1:0]   opK;
  logic            outValid;
  logic            outReady;
  logic [2*W-1:0]  zOut;

  approx_mul_pipe #(.W(W), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .k         (opK),
    .out_valid (outValid),
    .out_ready (outReady),
    .z         (zOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cmpCount = 0;
  int unsigned errCount = 0;
  int unsigned outCount = 0;
  logic [2*W-1:0] curExp;
  logic [2*W-1:0] sbQ [$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [KW-1:0]  k;
    logic [2*W-1:0] z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift out the truncated bits, then optionally set the midpoint bit.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [KW-1:0] kk);
    int unsigned     e;
    logic [2*W-1:0]  tx;
    logic [2*W-1:0]  ty;
    e  = (kk > W) ? W : int'(kk);
    tx = (2*W)'(x) >> e;
    tx = tx << e;
    ty = (2*W)'(y) >> e;
    ty = ty << e;
`ifdef APPROX_MUL_MIDPOINT_EN
    if (e > 0) begin
      tx[e-1] = 1'b1;
      ty[e-1] = 1'b1;
    end
`endif
    return tx * ty;
  endfunction

  // Scoreboard: transfers are decided by the values stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
    end else begin
      if (outValid && outReady) begin
        outCount++;
        cmpCount++;
        if (sbQ.size() == 0) begin
          errCount++;
          $display("FAIL sb_unexpected: got z=0x%0h expected no output at %0t", zOut, $time);
        end else begin
          logic [2*W-1:0] e;
          e = sbQ.pop_front();
          if (zOut !== e) begin
            errCount++;
            $display("FAIL sb_z: got 0x%0h expected 0x%0h at %0t", zOut, e, $time);
          end
        end
      end
      if (inValid && inReady) sbQ.push_back(curExp);
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic [KW-1:0] kk,
                       input logic [2*W-1:0] e);
    opA     = x;
    opB     = y;
    opK     = kk;
    curExp  = e;
    inValid = 1'b1;
  endtask

  // Called at posedge+1 with the pipe empty or draining; checks 2-cycle latency.
  task automatic latencyCheck(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [KW-1:0] kk, input logic [2*W-1:0] e);
    drive(x, y, kk, e);
    #1 check("lat_in_ready", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    check("lat_valid_n", 32'(outValid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_n1", 32'(outValid), 32'd1);
    check("lat_z", 32'(zOut), 32'(e));
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sbQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [8];
  logic [2*W-1:0] stallExp [3];
  logic [W-1:0]   stallA [3];
  logic [W-1:0]   stallB [3];
  logic [9:0]     validTrace;
  int unsigned    idx;
  int unsigned    outBefore;

  initial begin
`ifdef APPROX_MUL_MIDPOINT_EN
    vecs[0] = '{12'hABC, 12'h123, 4'd0,  24'h0C33B4};
    vecs[1] = '{12'hFFF, 12'hFFF, 4'd6,  24'hFC0400};
    vecs[2] = '{12'hFFF, 12'hFFF, 4'd15, 24'h400000};
    vecs[3] = '{12'hFFF, 12'hFFF, 4'd0,  24'hFFE001};
    vecs[4] = '{12'h000, 12'hFFF, 4'd0,  24'h000000};
    vecs[5] = '{12'h800, 12'h800, 4'd11, 24'h900000};
    vecs[6] = '{12'hFFF, 12'h001, 4'd1,  24'h000FFF};
    vecs[7] = '{12'h123, 12'h456, 4'd12, 24'h400000};
`else
    vecs[0] = '{12'hABC, 12'h123, 4'd0,  24'h0C33B4};
    vecs[1] = '{12'hFFF, 12'hFFF, 4'd6,  24'hF81000};
    vecs[2] = '{12'hFFF, 12'hFFF, 4'd15, 24'h000000};
    vecs[3] = '{12'hFFF, 12'hFFF, 4'd0,  24'hFFE001};
    vecs[4] = '{12'h000, 12'hFFF, 4'd0,  24'h000000};
    vecs[5] = '{12'h800, 12'h800, 4'd11, 24'h400000};
    vecs[6] = '{12'hFFF, 12'h001, 4'd1,  24'h000000};
    vecs[7] = '{12'h123, 12'h456, 4'd12, 24'h000000};
`endif

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    opA      = '0;
    opB      = '0;
    opK      = '0;
    curExp   = '0;

    // Reset state held for a few cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(inReady), 32'd1);
      check("rst_out_valid", 32'(outValid), 32'd0);
      check("rst_z", 32'(zOut), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors, each with a latency check.
    for (int i = 0; i < 8; i++) begin
      latencyCheck(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].z);
    end
    drain();

    // Back-to-back stream of 8 pairs with out_ready held high.
    validTrace = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [KW-1:0] kk;
        x  = W'($urandom);
        y  = W'($urandom);
        kk = KW'($urandom_range(0, 15));
        drive(x, y, kk, model(x, y, kk));
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("stream_in_ready", 32'(inReady), 32'd1);
      validTrace[i] = outValid;
      @(posedge clk); #1;
    end
    check("stream_valid_trace", 32'(validTrace), 32'h3FC);
    drain();

    // Stall: out_ready low for 5 cycles while in_valid stays high.
    for (int i = 0; i < 3; i++) begin
      stallA[i]   = W'($urandom);
      stallB[i]   = W'($urandom);
      stallExp[i] = model(stallA[i], stallB[i], 4'd2);
    end
    outReady = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      drive(stallA[idx], stallB[idx], 4'd2, stallExp[idx]);
      @(negedge clk);
      if (i >= 2) begin
        check("stall_in_ready", 32'(inReady), 32'd0);
        check("stall_out_valid", 32'(outValid), 32'd1);
        check("stall_z", 32'(zOut), 32'(stallExp[0]));
      end
      if (inReady && idx < 2) idx++;
      @(posedge clk); #1;
    end
    check("stall_accepts", idx, 32'd2);
    outBefore = outCount;
    inValid  = 1'b0;
    outReady = 1'b1;
    drain();
    check("stall_drain_count", outCount - outBefore, 32'd2);

    // Reset with two transactions in flight.
    drive(12'h111, 12'h222, 4'd0, model(12'h111, 12'h222, 4'd0));
    @(posedge clk); #1;
    drive(12'h333, 12'h444, 4'd0, model(12'h333, 12'h444, 4'd0));
    @(posedge clk); #1;
    inValid = 1'b0;
    check("pre_rst_out_valid", 32'(outValid), 32'd1);
    outBefore = outCount;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(outValid), 32'd0);
    check("async_rst_in_ready", 32'(inReady), 32'd1);
    check("async_rst_z", 32'(zOut), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    latencyCheck(12'h0F0, 12'h00F, 4'd3, model(12'h0F0, 12'h00F, 4'd3));
    drain();
    check("post_rst_out_count", outCount - outBefore, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
